// File: rtl/taxi_rst_seq_pkg.sv
// rtl/taxi_rst_seq_pkg.sv - shared types and constants for the reset sequencer
package taxi_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int LOSS_CNT_W = 8;

  // Saturating increment: the loss counter sticks at all ones.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/taxi_rst_seq_lock_filt.sv
// rtl/taxi_rst_seq_lock_filt.sv - lock synchronizer and consecutive-high debounce
module taxi_rst_seq_lock_filt #(
  parameter int SYNC_N    = 2,
  parameter int LOCK_FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_in,
  input  logic en,
  output logic lock_s,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);

  logic [SYNC_N-1:0] sync_q;
  logic [FW-1:0]     filt_cnt;

  // Plain shift-register synchronizer; cleared so lock is never assumed at reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_N-2:0], lock_in};
  end

  assign lock_s = sync_q[SYNC_N-1];

  // Count consecutive high samples while enabled; any low sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    filt_cnt <= '0;
    else if (!en || !lock_s)    filt_cnt <= '0;
    else if (filt_cnt != FILT_LAST) filt_cnt <= filt_cnt + FW'(1);
  end

  assign lock_ok = en && lock_s && (filt_cnt == FILT_LAST);

endmodule

// File: rtl/taxi_rst_seq.sv
// rtl/taxi_rst_seq.sv - ordered domain reset release after PLL lock; optional TAXI_RST_SEQ_TIMEOUT_EN
module taxi_rst_seq
  import taxi_rst_seq_pkg::*;
#(
  parameter int N_DOM        = 3,
  parameter int SYNC_N       = 2,
  parameter int LOCK_FILT    = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int STEP_CYCLES  = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_in,
  input  logic                  sw_rst_req,
  output logic [N_DOM-1:0]      rst_out,
  output logic                  ready,
  output logic [2:0]            state_out,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  lock_timeout
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int IW = $clog2(N_DOM + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOM - 1);

  state_t                  state, state_n;
  logic [HW-1:0]           hold_cnt, hold_cnt_n;
  logic [SW-1:0]           step_cnt, step_cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [N_DOM-1:0]        rst_out_n;
  logic                    ready_n;
  logic [LOSS_CNT_W-1:0]   loss_n;
  logic                    lock_s, lock_ok;

  taxi_rst_seq_lock_filt #(
    .SYNC_N    (SYNC_N),
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filt (
    .clk     (clk),
    .rst     (rst),
    .lock_in (lock_in),
    .en      (state == ST_WAIT_LOCK),
    .lock_s  (lock_s),
    .lock_ok (lock_ok)
  );

  // Next-state and next-output logic; lock loss outranks the software request.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    step_cnt_n = step_cnt;
    idx_n      = idx;
    rst_out_n  = rst_out;
    ready_n    = ready;
    loss_n     = lock_loss_cnt;
    case (state)
      ST_RESET: begin
        state_n   = ST_WAIT_LOCK;
        rst_out_n = '1;
        ready_n   = 1'b0;
      end
      ST_WAIT_LOCK: begin
        rst_out_n = '1;
        ready_n   = 1'b0;
        if (lock_ok) begin
          state_n    = ST_HOLD;
          hold_cnt_n = '0;
        end
      end
      ST_HOLD: begin
        rst_out_n = '1;
        ready_n   = 1'b0;
        if (!lock_s) begin
          state_n = ST_WAIT_LOCK;
        end else if (sw_rst_req) begin
          hold_cnt_n = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n    = ST_RELEASE;
          idx_n      = '0;
          step_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          state_n   = ST_WAIT_LOCK;
          rst_out_n = '1;
        end else if (sw_rst_req) begin
          state_n    = ST_HOLD;
          rst_out_n  = '1;
          hold_cnt_n = '0;
        end else if (step_cnt == STEP_LAST) begin
          step_cnt_n = '0;
          for (int i = 0; i < N_DOM; i++) begin
            if (IW'(i) == idx) rst_out_n[i] = 1'b0;
          end
          if (idx == IDX_LAST) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          step_cnt_n = step_cnt + SW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_n   = ST_WAIT_LOCK;
          rst_out_n = '1;
          ready_n   = 1'b0;
          loss_n    = sat_inc(lock_loss_cnt);
        end else if (sw_rst_req) begin
          state_n    = ST_HOLD;
          rst_out_n  = '1;
          ready_n    = 1'b0;
          hold_cnt_n = '0;
        end
      end
      default: begin
        state_n   = ST_WAIT_LOCK;
        rst_out_n = '1;
        ready_n   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset holds every domain in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RESET;
      hold_cnt      <= '0;
      step_cnt      <= '0;
      idx           <= '0;
      rst_out       <= '1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_cnt_n;
      step_cnt      <= step_cnt_n;
      idx           <= idx_n;
      rst_out       <= rst_out_n;
      ready         <= ready_n;
      lock_loss_cnt <= loss_n;
    end
  end

  assign state_out = state;

`ifdef TAXI_RST_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);

  logic [TW-1:0] to_cnt;

  // Time spent waiting for lock; flag sticks until WAIT_LOCK is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt       <= '0;
      lock_timeout <= 1'b0;
    end else if (state_n != ST_WAIT_LOCK) begin
      to_cnt       <= '0;
      lock_timeout <= 1'b0;
    end else if (state == ST_WAIT_LOCK) begin
      if (to_cnt == TO_LAST) lock_timeout <= 1'b1;
      else                   to_cnt       <= to_cnt + TW'(1);
    end
  end
`else
  // Timeout logic not built; the parameter stays so both builds share one interface.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^LOCK_TIMEOUT;
  assign lock_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_taxi_rst_seq.sv
// tb/tb_taxi_rst_seq.sv - directed scoreboard bench for taxi_rst_seq
module tb_taxi_rst_seq;

  localparam int HOLD = 16;
  localparam int STEP = 8;
`ifdef TAXI_RST_SEQ_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_out;
  logic       ready;
  logic [2:0] state_out;
  logic [7:0] lock_loss_cnt;
  logic       lock_timeout;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_loss = 0;

  typedef struct packed {
    logic [31:0] at;
    logic [2:0]  st;
    logic [2:0]  ro;
    logic        rdy;
    logic [95:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  taxi_rst_seq #(
    .N_DOM        (3),
    .SYNC_N       (2),
    .LOCK_FILT    (4),
    .HOLD_CYCLES  (HOLD),
    .STEP_CYCLES  (STEP),
    .LOCK_TIMEOUT (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lock_in       (lock_in),
    .sw_rst_req    (sw_rst_req),
    .rst_out       (rst_out),
    .ready         (ready),
    .state_out     (state_out),
    .lock_loss_cnt (lock_loss_cnt),
    .lock_timeout  (lock_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [95:0] tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %0s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int at, input logic [2:0] st, input logic [2:0] ro,
                           input logic rdy, input logic [95:0] tag);
    sb.push_back('{at: at, st: st, ro: ro, rdy: rdy, tag: tag});
  endtask

  // Expected release sequence for a HOLD entry at edge h.
  task automatic push_release(input int h, input logic [95:0] tag);
    expect_at(h,                   3'd2, 3'b111, 1'b0, tag);
    expect_at(h + HOLD - 1,        3'd2, 3'b111, 1'b0, tag);
    expect_at(h + HOLD + STEP - 1, 3'd3, 3'b111, 1'b0, tag);
    expect_at(h + HOLD + STEP,     3'd3, 3'b110, 1'b0, tag);
    expect_at(h + HOLD + 2*STEP,   3'd3, 3'b100, 1'b0, tag);
    expect_at(h + HOLD + 3*STEP-1, 3'd3, 3'b100, 1'b0, tag);
    expect_at(h + HOLD + 3*STEP,   3'd4, 3'b000, 1'b1, tag);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int lim;
    lim = cyc + 200;
    while (sb.size() > 0 && cyc < lim) @(negedge clk);
    if (sb.size() > 0) begin
      chk("sb_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Scoreboard monitor: compare cycle, state, rst_out and ready at each due entry.
  always @(negedge clk) begin
    while (sb.size() > 0 && int'(sb[0].at) <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, {cyc[24:0], state_out, rst_out, ready},
          {mon_e.at[24:0], mon_e.st, mon_e.ro, mon_e.rdy});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, x, h, w;
    rst = 1'b1;
    lock_in = 1'b1;
    sw_rst_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_state", {state_out, rst_out, ready}, {3'd0, 3'b111, 1'b0});
    chk("rst_loss", lock_loss_cnt, 0);
    chk("rst_to", lock_timeout, 0);

    // Power-up release with lock present throughout
    rst = 1'b0;
    r = cyc;
    expect_at(r + 1, 3'd1, 3'b111, 1'b0, "t1_wait");
    expect_at(r + 5, 3'd1, 3'b111, 1'b0, "t1_filt");
    push_release(r + 6, "t1_rel");
    drain();

    // Lock loss in RUN for 10 cycles
    c = cyc;
    lock_in = 1'b0;
    expect_at(c + 2, 3'd4, 3'b000, 1'b1, "t3_run");
    expect_at(c + 3, 3'd1, 3'b111, 1'b0, "t3_loss");
    wait_until(c + 3);
    exp_loss++;
    chk("t3_cnt", lock_loss_cnt, exp_loss);
    wait_until(c + 10);
    lock_in = 1'b1;
    x = cyc;
    push_release(x + 6, "t3_rel");
    drain();

    // Lock glitch while waiting for lock: 3 high, 1 low, then steady high
    c = cyc;
    lock_in = 1'b0;
    wait_until(c + 3);
    exp_loss++;
    chk("t2_cnt", lock_loss_cnt, exp_loss);
    wait_until(c + 5);
    x = cyc;
    lock_in = 1'b1;
    expect_at(x + 6, 3'd1, 3'b111, 1'b0, "t2_glitch");
    expect_at(x + 9, 3'd1, 3'b111, 1'b0, "t2_filt");
    push_release(x + 10, "t2_rel");
    wait_until(x + 3);
    lock_in = 1'b0;
    wait_until(x + 4);
    lock_in = 1'b1;
    drain();

    // Software reset in RUN, then again mid-release with rst_out = 110
    c = cyc;
    sw_rst_req = 1'b1;
    h = c + 1;
    expect_at(h,               3'd2, 3'b111, 1'b0, "t4_swrun");
    expect_at(h + HOLD + STEP, 3'd3, 3'b110, 1'b0, "t4_dom0");
    expect_at(h + HOLD + STEP + 2, 3'd3, 3'b110, 1'b0, "t4_pre");
    push_release(h + HOLD + STEP + 3, "t4_restart");
    wait_until(h);
    sw_rst_req = 1'b0;
    chk("t4_cnt", lock_loss_cnt, exp_loss);
    wait_until(h + HOLD + STEP + 2);
    sw_rst_req = 1'b1;
    wait_until(h + HOLD + STEP + 3);
    sw_rst_req = 1'b0;
    drain();

    // Lock loss and software request on the same edge in RUN
    c = cyc;
    lock_in = 1'b0;
    expect_at(c + 3, 3'd1, 3'b111, 1'b0, "t5_both");
    wait_until(c + 2);
    sw_rst_req = 1'b1;
    wait_until(c + 3);
    sw_rst_req = 1'b0;
    exp_loss++;
    chk("t5_cnt", lock_loss_cnt, exp_loss);
    wait_until(c + 5);

    // 300 lock losses: the counter must stop at 255
    w = 0;
    for (int i = 0; i < 300; i++) begin
      x = cyc;
      lock_in = 1'b1;
      wait_until(x + 6 + HOLD + 3*STEP);
      chk("sat_run", state_out, 4);
      c = cyc;
      lock_in = 1'b0;
      wait_until(c + 3);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      chk("sat_cnt", lock_loss_cnt, exp_loss);
      w = c + 3;
      wait_until(c + 5);
    end
    chk("sat_final", lock_loss_cnt, 255);

    // Lock timeout while lock stays low, cleared on HOLD entry
    wait_until(w + 31);
    chk("t6_pre", lock_timeout, 0);
    wait_until(w + 32);
    chk("t6_rise", lock_timeout, TO_EXP);
    wait_until(w + 40);
    chk("t6_stay", {state_out, lock_timeout}, {3'd1, TO_EXP});
    x = cyc;
    lock_in = 1'b1;
    wait_until(x + 5);
    chk("t6_wait", {state_out, lock_timeout}, {3'd1, TO_EXP});
    wait_until(x + 6);
    chk("t6_clr", {state_out, lock_timeout}, {3'd2, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/taxi_rst_seq.md
Name: taxi_rst_seq

Overview:
- Reset sequencer for the 10G MAC/PHY subsystem.
- Holds all downstream domain resets asserted until the SERDES/PLL lock is stable, then releases them one at a time in a fixed order, each after a programmable spacing.
- Re-asserts all resets on loss of lock or on a software reset request.
- Each rst_out bit feeds a per-domain taxi_sync_reset instance in the consuming clock domain.

Parameters:
- N_DOM, 3: number of reset domains; bit 0 is released first. Must be ≥1.
- SYNC_N, 2: lock_in synchronizer depth. Must be ≥2.
- LOCK_FILT, 4: consecutive synchronized-high cycles of lock required to accept lock. Must be ≥1.
- HOLD_CYCLES, 16: cycles all resets stay asserted after lock is accepted. Must be ≥1.
- STEP_CYCLES, 8: cycles between successive domain releases. Must be ≥1.
- LOCK_TIMEOUT, 1024: WAIT_LOCK timeout in cycles. Used only with the optional feature.

Ports:
- clk, in, 1: sequencer clock (free-running reference clock).
- rst, in, 1: reset, asynchronous, active-high.
- lock_in, in, 1: PLL/CDR lock, asynchronous to clk.
- sw_rst_req, in, 1: synchronous single-cycle software reset request.
- rst_out, out, N_DOM: active-high domain resets, registered.
- ready, out, 1: all domains released, registered.
- state_out, out, 3: current FSM state encoding, for debug.
- lock_loss_cnt, out, 8: saturating count of lock losses seen in RUN.
- lock_timeout, out, 1: WAIT_LOCK timeout flag (optional feature).

Behaviour:
- Reset (rst high, asynchronous):
  - state = RESET; rst_out = all ones; ready = 0; lock_loss_cnt = 0; lock_timeout = 0.
  - All counters cleared; synchronizer flops set to 0.
- lock_in passes through a SYNC_N-flop synchronizer to give lock_s.
- RESET → WAIT_LOCK unconditionally on the first clk edge after rst deasserts.
- WAIT_LOCK:
  - Filter counter increments while lock_s = 1 and clears when lock_s = 0.
  - When the counter reaches LOCK_FILT-1 with lock_s = 1, go to HOLD.
  - sw_rst_req is ignored.
- HOLD:
  - rst_out stays all ones; hold counter runs 0..HOLD_CYCLES-1, then go to RELEASE.
  - lock_s = 0 → WAIT_LOCK.
  - sw_rst_req → hold counter restarts at 0.
- RELEASE:
  - On entry idx = 0 and step timer = 0.
  - When the timer reaches STEP_CYCLES-1: clear rst_out[idx], increment idx, reset the timer.
  - On the edge that clears rst_out[N_DOM-1]: state = RUN and ready = 1 on the same edge.
  - lock_s = 0 → rst_out all ones, go to WAIT_LOCK.
  - sw_rst_req → rst_out all ones, go to HOLD.
- RUN:
  - ready = 1; rst_out = 0.
  - lock_s = 0 → next edge: rst_out all ones, ready = 0, lock_loss_cnt increments (saturates at 255), go to WAIT_LOCK.
  - sw_rst_req → next edge: rst_out all ones, ready = 0, go to HOLD. lock_loss_cnt is unchanged.
- Priority: rst > lock loss > sw_rst_req.
- Release order is strictly ascending. Re-assertion is always simultaneous across all domains.
- No released domain is ever re-released without first passing through HOLD.
- Counter widths are $clog2(max+1) and never wrap; each counter stops at its terminal value.
- State encoding: RESET = 0, WAIT_LOCK = 1, HOLD = 2, RELEASE = 3, RUN = 4.
- Release timing: rst_out[k] falls exactly HOLD_CYCLES + (k+1)·STEP_CYCLES cycles after the edge entering HOLD.

Optional Feature:
- Macro: TAXI_RST_SEQ_TIMEOUT_EN.
- Defined:
  - A timeout counter runs while in WAIT_LOCK and clears on leaving it.
  - Reaching LOCK_TIMEOUT-1 sets lock_timeout.
  - lock_timeout stays set until the FSM leaves WAIT_LOCK, or rst asserts.
  - The FSM remains in WAIT_LOCK.
- Undefined: lock_timeout is tied to 0 and no timeout counter is built.

Decomposition:
- Package taxi_rst_seq_pkg:
  - state typedef enum logic [2:0] with the encodings above.
  - localparam for the lock_loss_cnt width (8).
- Sub-module taxi_rst_seq_lock_filt:
  - Contains the SYNC_N synchronizer plus the LOCK_FILT debounce.
  - Outputs lock_s and lock_ok (lock accepted).
- Top level holds the FSM, the hold/step counters, and the output registers.

Test Plan:
1. Power-up, defaults: rst high 5 cycles, lock_in = 1 throughout → rst_out = 3'b111 until 16+8 cycles after HOLD entry; then 3'b110, 3'b100, 3'b000 at 8-cycle spacing; ready rises with the last release; state_out ends at 4.
2. Lock glitch in WAIT_LOCK: lock_in high 3 cycles, low 1, then high → HOLD is entered only after 4 consecutive lock_s-high cycles; rst_out stays 3'b111.
3. Lock loss in RUN: drop lock_in for 10 cycles → rst_out = 3'b111 and ready = 0 one cycle after lock_s falls; lock_loss_cnt = 1; full release sequence repeats after lock returns.
4. sw_rst_req during RELEASE when rst_out = 3'b110 → next edge rst_out = 3'b111, state_out = 2; release restarts from domain 0.
5. Simultaneous lock loss and sw_rst_req in RUN → state_out = 1 (WAIT_LOCK), lock_loss_cnt increments; 300 lock losses → lock_loss_cnt saturates at 255.
6. With TAXI_RST_SEQ_TIMEOUT_EN, LOCK_TIMEOUT = 32, lock_in held 0 → lock_timeout rises at cycle 32 of WAIT_LOCK and clears on HOLD entry after lock returns; without the macro, lock_timeout is always 0.
